fadd_calc_norm: RTL and testbench
=================================

FADD_CALC_NORM -- requirements
Module: fadd_calc_norm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream alignment-stage result valid.
REQ-005 in_ready  output  1  block can accept this cycle.
REQ-006 in_sign  input  1  result sign from alignment.
REQ-007 in_exp  input  8  larger operand's biased exponent.
REQ-008 in_op_sub  input  1  1 = subtract fractions, 0 = add.
REQ-009 in_large_frac24  input  24  hidden bit plus fraction of the larger operand.
REQ-010 in_small_frac27  input  27  aligned smaller fraction: [26:3] mantissa, [2] guard, [1] round, [0] sticky.
REQ-011 out_valid  output  1  out_result and out_overflow are valid.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_result  output  32  IEEE-754 single-precision sum.
REQ-014 out_overflow  output  1  result saturated to infinity.

Function
REQ-015 Transfer rule: accept when in_valid&&in_ready; deliver when out_valid&&out_ready.
REQ-016 Two register stages, v1 and v2; stage 2 loads when !v2||out_ready, stage 1 loads when !v1||(stage 2 loads).
REQ-017 in_ready = !v1 || !v2 || out_ready (combinational); throughput is one result per cycle.
REQ-018 Latency: an item accepted at edge N gives out_valid=1 after edge N+1 when stage 2 is free.
REQ-019 Stage 1 registers sign, exp and frac28 = {0,large,000} minus {0,small27} when op_sub=1, else the sum; all arithmetic is 28-bit unsigned.
REQ-020 Stage 2 normalise, case frac28[27]=1: shift right 1, OR the dropped bit into sticky, exp+1.
REQ-021 Stage 2 normalise, otherwise: z = leading-zero count of frac28[26:0]; if exp>z, shift left z and exp-z; else shift left max(exp-1,0) and exponent 0 (denormal).
REQ-022 frac28==0 SHALL give out_result=0x00000000 (+0).
REQ-023 Rounding is applied to the normalised 27 bits (24 mantissa bits plus g, r, s).
REQ-024 A rounding carry out of the mantissa SHALL shift right 1 and increment exp; a denormal rounding into hidden-bit position SHALL set exp=1.
REQ-025 A final exp >= 255 SHALL give out_result={sign,8'hFF,23'h0} and out_overflow=1; otherwise out_overflow=0.
REQ-026 While out_valid&&!out_ready, out_result, out_overflow and out_valid SHALL hold stable.
REQ-027 Simultaneous accept and deliver with both stages full SHALL advance both stages with no loss or duplication.

Reset
REQ-028 rst_n low SHALL immediately clear v1, v2, out_valid, out_result (0x00000000), out_overflow (0) and stage-1 registers.
REQ-029 Reset mid-operation SHALL discard in-flight items; in_ready=1 on the first cycle after release.

Configuration
REQ-030 Macro FADD_ROUND_EN defined: round-to-nearest-even, increment iff g&&(r||s||lsb).
REQ-031 Macro FADD_ROUND_EN undefined: truncation; g, r and s are discarded, and no rounding carry or exponent increment from rounding occurs.

Verification
REQ-032 1.0+1.0: sign0, exp 0x7F, op_sub0, large 0x800000, small27 0x4000000 -> 0x40000000, overflow 0, two cycles later.
REQ-033 1.0-1.0: same operands, op_sub1 -> 0x00000000.
REQ-034 Overflow: exp 0xFE, large 0xFFFFFF, small27 0x7FFFFF8, op_sub0 -> 0x7F800000, out_overflow=1.
REQ-035 Rounding: exp 0x7F, large 0x800000, small27 0x0000004 -> 0x3F800000 (tie to even).
REQ-036 Rounding, sticky set: small27 0x0000005 -> 0x3F800001 with FADD_ROUND_EN, 0x3F800000 without.
REQ-037 Backpressure: out_ready=0 with 3 back-to-back inputs -> 2 accepted, in_ready=0 and out_result held; out_ready=1 -> results in order, then the third.
REQ-038 Reset: assert rst_n low with both stages full -> out_valid=0 immediately; no stale result appears after release.

Source files
------------

// File: rtl/fadd_calc_norm.sv
// fadd_calc_norm
//   Final stage of a single-precision adder. Takes the aligned operands from
//   the alignment stage, adds or subtracts the fractions, normalises the sum,
//   rounds it and packs the IEEE-754 result.
//
//   Pipeline: stage 1 holds the raw 28-bit sum; stage 2 holds the packed
//   result. Both stages use valid/ready handshakes with full throughput.
//
//   Build option:
//     FADD_ROUND_EN defined   -> round-to-nearest-even on guard/round/sticky
//     FADD_ROUND_EN undefined -> truncation (g/r/s discarded)
module fadd_calc_norm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic        in_op_sub,
  input  logic [23:0] in_large_frac24,
  input  logic [26:0] in_small_frac27,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow
);

  // Stage 1 registers
  logic        r_v1;
  logic        r_sign1;
  logic [7:0]  r_exp1;
  logic [27:0] r_frac1;

  // Stage 2 registers
  logic        r_v2;
  logic [31:0] r_result;
  logic        r_ovf;

  // Handshake
  logic        w_ld1;
  logic        w_ld2;
  logic        w_acc;

  // Datapath
  logic [27:0] w_large28;
  logic [27:0] w_small28;
  logic [27:0] w_sum28;
  logic [4:0]  w_lz;
  logic [7:0]  w_sh;
  logic [26:0] w_n27;
  logic [8:0]  w_exp_n;
  logic        w_inc;
  logic [24:0] w_m25;
  logic [23:0] w_mant;
  logic [8:0]  w_exp_f;
  logic        w_ovf;
  logic        w_zero;
  logic [31:0] w_res;

  // Leading-zero count of a 27-bit vector; 27 when the vector is all zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  assign w_ld2    = !r_v2 || out_ready;
  assign w_ld1    = !r_v1 || w_ld2;
  assign in_ready = !r_v1 || !r_v2 || out_ready;
  assign w_acc    = in_valid && in_ready;

  assign w_large28 = {1'b0, in_large_frac24, 3'b000};
  assign w_small28 = {1'b0, in_small_frac27};
  assign w_sum28   = in_op_sub ? (w_large28 - w_small28) : (w_large28 + w_small28);

  // Stage 1: capture sign, exponent and the raw fraction sum of an accepted item
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_sign1 <= 1'b0;
      r_exp1  <= 8'h00;
      r_frac1 <= 28'h0;
    end else if (w_ld1) begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_sign1 <= in_sign;
        r_exp1  <= in_exp;
        r_frac1 <= w_sum28;
      end
    end
  end

  assign w_lz = lzc27(r_frac1[26:0]);

  // Normalise: right shift on carry-out, else left shift limited by the exponent
  always_comb begin
    w_sh    = 8'h00;
    w_n27   = r_frac1[26:0];
    w_exp_n = {1'b0, r_exp1};
    if (r_frac1[27]) begin
      // dropped LSB folds into sticky so rounding still sees it
      w_n27   = {r_frac1[27:2], r_frac1[1] | r_frac1[0]};
      w_exp_n = {1'b0, r_exp1} + 9'd1;
    end else if (r_exp1 > {3'b000, w_lz}) begin
      w_n27   = r_frac1[26:0] << w_lz;
      w_exp_n = {1'b0, r_exp1} - {4'b0000, w_lz};
    end else begin
      // not enough exponent range: produce a denormal
      w_sh    = (r_exp1 != 8'h00) ? (r_exp1 - 8'h01) : 8'h00;
      w_n27   = r_frac1[26:0] << w_sh;
      w_exp_n = 9'd0;
    end
  end

`ifdef FADD_ROUND_EN
  // nearest-even: bump when above half, or exactly half with an odd LSB
  assign w_inc = w_n27[2] && (w_n27[1] || w_n27[0] || w_n27[3]);
`else
  logic w_unused_grs;
  assign w_unused_grs = ^w_n27[2:0];
  assign w_inc        = 1'b0;
`endif

  assign w_m25 = {1'b0, w_n27[26:3]} + {24'h000000, w_inc};

  // Post-rounding fix-up: mantissa carry-out, or a denormal rounding up to normal
  always_comb begin
    w_mant  = w_m25[23:0];
    w_exp_f = w_exp_n;
    if (w_m25[24]) begin
      w_mant  = w_m25[24:1];
      w_exp_f = w_exp_n + 9'd1;
    end else if ((w_exp_n == 9'd0) && w_mant[23] && w_inc) begin
      w_exp_f = 9'd1;
    end
  end

  assign w_zero = (r_frac1 == 28'h0);
  assign w_ovf  = !w_zero && (w_exp_f >= 9'd255);

  // Pack; an exact zero sum is always +0 regardless of operand sign
  always_comb begin
    w_res = {r_sign1, w_exp_f[7:0], w_mant[22:0]};
    if (w_zero) begin
      w_res = 32'h0000_0000;
    end else if (w_ovf) begin
      w_res = {r_sign1, 8'hFF, 23'h000000};
    end
  end

  // Stage 2: register the packed result; holds while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2     <= 1'b0;
      r_result <= 32'h0000_0000;
      r_ovf    <= 1'b0;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
      end
    end
  end

  assign out_valid    = r_v2;
  assign out_result   = r_result;
  assign out_overflow = r_ovf;

endmodule

// File: tb/tb_fadd_calc_norm.sv
// Testbench for fadd_calc_norm: directed vectors, backpressure, reset
// mid-flight and a randomised stream, all checked through a scoreboard.
module tb_fadd_calc_norm;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic        in_op_sub;
  logic [23:0] in_large_frac24;
  logic [26:0] in_small_frac27;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;

  exp_t sb[$];
  exp_t cur_exp;
  int   checks;
  int   failures;
  bit   last_acc;

  fadd_calc_norm dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_sign         (in_sign),
    .in_exp          (in_exp),
    .in_op_sub       (in_op_sub),
    .in_large_frac24 (in_large_frac24),
    .in_small_frac27 (in_small_frac27),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_overflow    (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bit-by-bit normalisation loop, then optional RNE
  function automatic exp_t model(input logic s, input logic [7:0] ex, input logic sub,
                                 input logic [23:0] lg, input logic [26:0] sm);
    logic [27:0] a;
    logic [27:0] b;
    logic [27:0] f;
    logic [24:0] m;
    int          e;
    exp_t        o;
    a = {1'b0, lg, 3'b000};
    b = {1'b0, sm};
    f = sub ? (a - b) : (a + b);
    if (f == 28'h0) begin
      o.res = 32'h0;
      o.ovf = 1'b0;
      return o;
    end
    e = int'(ex);
    if (f[27]) begin
      f = {1'b0, f[27:2], f[1] | f[0]};
      e = e + 1;
    end else begin
      while (!f[26] && e > 1) begin
        f = f << 1;
        e = e - 1;
      end
      if (!f[26]) e = 0;
    end
    m = {1'b0, f[26:3]};
`ifdef FADD_ROUND_EN
    if (f[2] && (f[1] || f[0] || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e == 0 && m[23]) e = 1;
`endif
    if (e >= 255) begin
      o.res = {s, 8'hFF, 23'h0};
      o.ovf = 1'b1;
    end else begin
      o.res = {s, e[7:0], m[22:0]};
      o.ovf = 1'b0;
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic put(input logic s, input logic [7:0] e, input logic sub,
                     input logic [23:0] lg, input logic [26:0] sm, input exp_t ex);
    in_sign         = s;
    in_exp          = e;
    in_op_sub       = sub;
    in_large_frac24 = lg;
    in_small_frac27 = sm;
    cur_exp         = ex;
    in_valid        = 1'b1;
  endtask

  task automatic putm(input logic s, input logic [7:0] e, input logic sub,
                      input logic [23:0] lg, input logic [26:0] sm);
    put(s, e, sub, lg, sm, model(s, e, sub, lg, sm));
  endtask

  // One clock: check head of scoreboard against output, record accept, advance
  task automatic tick();
    #3;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        chk("result", out_result, sb[0].res);
        chk("overflow", {31'b0, out_overflow}, {31'b0, sb[0].ovf});
        if (out_ready) void'(sb.pop_front());
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick();
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [23:0] lg;
    logic [23:0] lg2;
    logic [26:0] sm;
    logic [7:0]  ex;
    int          sh;
    int          pick;
    bit          got;

    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    in_valid        = 1'b0;
    in_sign         = 1'b0;
    in_exp          = 8'h00;
    in_op_sub       = 1'b0;
    in_large_frac24 = 24'h0;
    in_small_frac27 = 27'h0;
    out_ready       = 1'b0;
    cur_exp         = '0;
    last_acc        = 1'b0;

    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_overflow", {31'b0, out_overflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 1.0 + 1.0 with latency check
    out_ready = 1'b1;
    put(1'b0, 8'h7F, 1'b0, 24'h800000, 27'h4000000, exp_t'{32'h40000000, 1'b0});
    tick();
    in_valid = 1'b0;
    chk("lat_after_accept", {31'b0, out_valid}, 32'd0);
    tick();
    chk("lat_two_edges", {31'b0, out_valid}, 32'd1);
    tick();

    // Back-to-back directed vectors
    put(1'b0, 8'h7F, 1'b1, 24'h800000, 27'h4000000, exp_t'{32'h00000000, 1'b0});
    tick();
    put(1'b0, 8'hFE, 1'b0, 24'hFFFFFF, 27'h7FFFFF8, exp_t'{32'h7F800000, 1'b1});
    tick();
    put(1'b0, 8'h7F, 1'b0, 24'h800000, 27'h0000004, exp_t'{32'h3F800000, 1'b0});
    tick();
`ifdef FADD_ROUND_EN
    put(1'b0, 8'h7F, 1'b0, 24'h800000, 27'h0000005, exp_t'{32'h3F800001, 1'b0});
`else
    put(1'b0, 8'h7F, 1'b0, 24'h800000, 27'h0000005, exp_t'{32'h3F800000, 1'b0});
`endif
    tick();
    put(1'b0, 8'h7F, 1'b1, 24'hC00000, 27'h5000000, exp_t'{32'h3E800000, 1'b0});
    tick();
    putm(1'b1, 8'h80, 1'b0, 24'hA00000, 27'h2800000);
    tick();
    putm(1'b0, 8'h01, 1'b1, 24'h800000, 27'h3FFFFF8);
    tick();
    putm(1'b0, 8'h03, 1'b1, 24'h800000, 27'h3FFFFF8);
    tick();
    putm(1'b1, 8'h90, 1'b1, 24'h800001, 27'h3FFFFFF);
    tick();
    putm(1'b0, 8'h7F, 1'b0, 24'hFFFFFF, 27'h000000C);
    tick();
    drain();

    // Backpressure: two items fill the pipe, third waits
    out_ready = 1'b0;
    putm(1'b0, 8'h81, 1'b0, 24'h900000, 27'h1000000);
    tick();
    putm(1'b1, 8'h82, 1'b1, 24'hF00000, 27'h0800000);
    tick();
    putm(1'b0, 8'h83, 1'b0, 24'hC00000, 27'h6000000);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("bp_accepted", 32'(sb.size()), 32'd2);
    tick();
    tick();
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_acc) begin
        got = 1'b1;
        break;
      end
    end
    chk("bp_third_accepted", {31'b0, got}, 32'd1);
    drain();

    // Reset with both stages full: nothing stale may emerge afterwards
    out_ready = 1'b0;
    putm(1'b0, 8'h85, 1'b0, 24'hABCDEF, 27'h1234567);
    tick();
    putm(1'b1, 8'h86, 1'b0, 24'h876543, 27'h0FEDCBA);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_full", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_out_result", out_result, 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale", {31'b0, out_valid}, 32'd0);
    end

    // Random stream with random downstream stalls
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        lg   = {1'b1, 23'($urandom)};
        lg2  = {1'b1, 23'($urandom)};
        sh   = $urandom_range(0, 30);
        sm   = 27'({lg2, 3'b000} >> sh) | 27'($urandom_range(0, 1));
        pick = $urandom_range(0, 5);
        ex   = (pick == 0) ? 8'h01 : (pick == 1) ? 8'hFE : (pick == 2) ? 8'h02
                                   : 8'($urandom_range(1, 254));
        putm(1'($urandom), ex, 1'($urandom), lg, sm);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
